// File: rtl/digit_scanner_if.sv
// Scan control/select bundle for digit_scanner: enable and direction in,
// one-hot select, channel index and slot-start pulse out.
interface digit_scanner_if #(
    parameter int N = 4
);
    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic         en;
    logic         dir;
    logic [N-1:0] sel;
    logic [W-1:0] idx;
    logic         slot_start;

    modport master (
        output en,
        output dir,
        input  sel,
        input  idx,
        input  slot_start
    );

    modport slave (
        input  en,
        input  dir,
        output sel,
        output idx,
        output slot_start
    );
endinterface

// File: rtl/digit_scanner.sv
// Time-multiplexed channel scanner with one-hot select and slot-start pulse.
// Optional dead-time blanking at the start of each slot: define SCAN_DEADTIME_EN.
module digit_scanner #(
    parameter int N    = 4,
    parameter int DIV  = 1000,
    parameter int DEAD = 1
) (
    input  logic          clk,
    input  logic          rst,
    digit_scanner_if.slave bus
);
    localparam int W  = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(DIV);

    localparam logic [W-1:0]  IDX_MAX = W'(N - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    generate
        if (N < 2 || N > 8) begin : g_bad_n
            $error("digit_scanner: N must be in 2..8");
        end
        if (DIV < 2 || DIV > 65535) begin : g_bad_div
            $error("digit_scanner: DIV must be in 2..65535");
        end
        if (DEAD < 0 || DEAD > DIV - 1) begin : g_bad_dead
            $error("digit_scanner: DEAD must be in 0..DIV-1");
        end
    endgenerate

    logic          act_r;
    logic [CW-1:0] cnt_r;
    logic [W-1:0]  idx_r;
    logic [W-1:0]  idx_next_s;
    logic          blank_s;
    logic [N-1:0]  sel_s;

`ifdef SCAN_DEADTIME_EN
    generate
        if (DEAD > 0) begin : g_dead
            assign blank_s = (cnt_r < CW'(DEAD));
        end else begin : g_no_dead
            assign blank_s = 1'b0;
        end
    endgenerate
`else
    assign blank_s = 1'b0;
`endif

    // Next channel index; dir only matters on the advance edge.
    always_comb begin
        idx_next_s = idx_r;
        if (bus.dir == 1'b0) begin
            if (idx_r == IDX_MAX) begin
                idx_next_s = {W{1'b0}};
            end else begin
                idx_next_s = idx_r + W'(1);
            end
        end else begin
            if (idx_r == {W{1'b0}}) begin
                idx_next_s = IDX_MAX;
            end else begin
                idx_next_s = idx_r - W'(1);
            end
        end
    end

    // Activity flag, slot counter and channel index.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_r <= 1'b0;
            cnt_r <= {CW{1'b0}};
            idx_r <= {W{1'b0}};
        end else begin
            act_r <= bus.en;
            if (!bus.en) begin
                cnt_r <= {CW{1'b0}};
            end else if (!act_r) begin
                // Re-enabled: this cycle is the first of a fresh slot.
                cnt_r <= {CW{1'b0}};
            end else if (cnt_r == CNT_MAX) begin
                cnt_r <= {CW{1'b0}};
                idx_r <= idx_next_s;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    // One-hot select decoded purely from registered state.
    always_comb begin
        sel_s = {N{1'b0}};
        if (act_r && !blank_s) begin
            sel_s[idx_r] = 1'b1;
        end else begin
            sel_s = {N{1'b0}};
        end
    end

    assign bus.sel        = sel_s;
    assign bus.idx        = idx_r;
    assign bus.slot_start = act_r && (cnt_r == {CW{1'b0}});

endmodule

// File: tb/tb_digit_scanner.sv
// Directed self-checking bench for digit_scanner (N=4/DIV=4/DEAD=1 and N=2/DIV=2/DEAD=0).
module tb_digit_scanner;
`ifdef SCAN_DEADTIME_EN
    localparam int DT = 1;
`else
    localparam int DT = 0;
`endif

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    digit_scanner_if #(.N(4)) bus4 ();
    digit_scanner_if #(.N(2)) bus2 ();

    digit_scanner #(.N(4), .DIV(4), .DEAD(1)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    digit_scanner #(.N(2), .DIV(2), .DEAD(0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected select for the 4-channel instance (DEAD=1 blank when enabled).
    function automatic logic [3:0] exp_sel4(int i, int c);
        logic [3:0] one;
        one = 4'b0001;
        if (DT == 1 && c < 1) return 4'b0000;
        return one << i;
    endfunction

    // Reset with EN held high, then release: leaves slot k=0 (idx 0, cnt 0) visible.
    task automatic start_scan();
        rst = 1'b1;
        bus4.en = 1'b1;
        bus4.dir = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus4.en = 1'b0; bus4.dir = 1'b0;
        bus2.en = 1'b0; bus2.dir = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tests++;
        if (bus4.sel !== 4'b0000 || bus4.idx !== 2'd0 || bus4.slot_start !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: sel=%b idx=%0d ss=%b, want sel=0000 idx=0 ss=0",
                     bus4.sel, bus4.idx, bus4.slot_start);
        end
    endtask

    task automatic test_scan_ascending();
        int i, c;
        start_scan();
        for (int k = 0; k < 20; k++) begin
            c = k % 4;
            i = (k / 4) % 4;
            tests++;
            if (bus4.sel !== exp_sel4(i, c) || bus4.idx !== 2'(i) ||
                bus4.slot_start !== (c == 0)) begin
                fails++;
                $display("FAIL scan_asc k=%0d: sel=%b idx=%0d ss=%b, want sel=%b idx=%0d ss=%0d",
                         k, bus4.sel, bus4.idx, bus4.slot_start, exp_sel4(i, c), i, (c == 0));
            end
            tests++;
            if (!$onehot0(bus4.sel)) begin
                fails++;
                $display("FAIL onehot k=%0d: sel=%b, want at most one bit", k, bus4.sel);
            end
            tick();
        end
    endtask

    task automatic test_direction_change();
        int exp_idx [14] = '{1, 1, 0, 0, 0, 0, 3, 3, 3, 3, 2, 2, 2, 2};
        int c;
        start_scan();
        for (int k = 0; k < 5; k++) tick();
        bus4.dir = 1'b1;
        for (int k = 0; k < 14; k++) begin
            tick();
            c = (k + 2) % 4;
            tests++;
            if (bus4.idx !== 2'(exp_idx[k]) || bus4.sel !== exp_sel4(exp_idx[k], c) ||
                bus4.slot_start !== (c == 0)) begin
                fails++;
                $display("FAIL dir_change step=%0d: idx=%0d sel=%b ss=%b, want idx=%0d sel=%b ss=%0d",
                         k, bus4.idx, bus4.sel, bus4.slot_start, exp_idx[k],
                         exp_sel4(exp_idx[k], c), (c == 0));
            end
        end
        bus4.dir = 1'b0;
    endtask

    task automatic test_enable_pause();
        start_scan();
        for (int k = 0; k < 10; k++) tick();
        bus4.en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            tests++;
            if (bus4.sel !== 4'b0000 || bus4.idx !== 2'd2 || bus4.slot_start !== 1'b0) begin
                fails++;
                $display("FAIL en_off %0d: sel=%b idx=%0d ss=%b, want sel=0000 idx=2 ss=0",
                         k, bus4.sel, bus4.idx, bus4.slot_start);
            end
        end
        bus4.en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            tests++;
            if (c < 4) begin
                if (bus4.sel !== exp_sel4(2, c) || bus4.idx !== 2'd2 ||
                    bus4.slot_start !== (c == 0)) begin
                    fails++;
                    $display("FAIL en_resume c=%0d: sel=%b idx=%0d ss=%b, want sel=%b idx=2 ss=%0d",
                             c, bus4.sel, bus4.idx, bus4.slot_start, exp_sel4(2, c), (c == 0));
                end
            end else begin
                if (bus4.idx !== 2'd3 || bus4.slot_start !== 1'b1) begin
                    fails++;
                    $display("FAIL en_next: idx=%0d ss=%b, want idx=3 ss=1",
                             bus4.idx, bus4.slot_start);
                end
            end
        end
    endtask

    task automatic test_reset_mid_slot();
        start_scan();
        for (int k = 0; k < 14; k++) tick();
        rst = 1'b1;
        tick();
        tests++;
        if (bus4.sel !== 4'b0000 || bus4.idx !== 2'd0 || bus4.slot_start !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid: sel=%b idx=%0d ss=%b, want sel=0000 idx=0 ss=0",
                     bus4.sel, bus4.idx, bus4.slot_start);
        end
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            tests++;
            if (bus4.idx !== 2'(k / 4) || bus4.sel !== exp_sel4(k / 4, k % 4) ||
                bus4.slot_start !== (k % 4 == 0)) begin
                fails++;
                $display("FAIL rst_resume k=%0d: idx=%0d sel=%b ss=%b, want idx=%0d sel=%b ss=%0d",
                         k, bus4.idx, bus4.sel, bus4.slot_start, k / 4,
                         exp_sel4(k / 4, k % 4), (k % 4 == 0));
            end
        end
    endtask

    task automatic test_two_phase();
        logic [1:0] exp_sel [8] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
        rst = 1'b1;
        bus2.en = 1'b1;
        bus2.dir = 1'b0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            tests++;
            if (bus2.sel !== exp_sel[k] || bus2.idx !== 1'((k / 2) % 2) ||
                bus2.slot_start !== (k % 2 == 0)) begin
                fails++;
                $display("FAIL two_phase k=%0d: sel=%b idx=%0d ss=%b, want sel=%b idx=%0d ss=%0d",
                         k, bus2.sel, bus2.idx, bus2.slot_start, exp_sel[k], (k / 2) % 2,
                         (k % 2 == 0));
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus4.en = 1'b0; bus4.dir = 1'b0;
        bus2.en = 1'b0; bus2.dir = 1'b0;
        test_reset();
        test_scan_ascending();
        test_direction_change();
        test_enable_pause();
        test_reset_mid_slot();
        test_two_phase();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/digit_scanner.md
DIGIT_SCANNER -- requirements
Module: digit_scanner

Interface
REQ-001 Parameter N, default 4, number of output channels; legal range 2..8.
REQ-002 Parameter DIV, default 1000, clock cycles per channel slot; legal range 2..65535.
REQ-003 Parameter DEAD, default 1, blanking cycles at the start of each slot; legal range 0..DIV-1.
REQ-004 Port CLK  in  1  single clock; all state changes on its rising edge.
REQ-005 Port RST  in  1  reset; synchronous, active-high.
REQ-006 Port EN  in  1  scan enable; 1 = scanning, 0 = all channels off.
REQ-007 Port DIR  in  1  scan direction; 0 = ascending index, 1 = descending index.
REQ-008 Port SEL  out  N  one-hot channel select, active-high; all-zero when blanked or idle.
REQ-009 Port IDX  out  W  current channel index, where W = clog2(N) with a minimum of 1.
REQ-010 Port SLOT_START  out  1  one-cycle pulse in the first cycle of every active slot.

Function
REQ-011 The internal registers SHALL be: act (1 bit), cnt (slot counter, 0..DIV-1) and idx (0..N-1).
REQ-012 Each cycle, act SHALL load EN.
REQ-013 EN=0: cnt SHALL load 0; idx SHALL hold.
REQ-014 EN=1 and act=0: cnt SHALL hold at 0; this is the first cycle of a fresh slot.
REQ-015 EN=1, act=1 and cnt<DIV-1: cnt SHALL increment by 1.
REQ-016 EN=1, act=1 and cnt=DIV-1: cnt SHALL load 0, and idx SHALL advance.
REQ-017 Advance rule: DIR=0 gives idx+1 (N-1 wraps to 0); DIR=1 gives idx-1 (0 wraps to N-1).
REQ-018 DIR SHALL be sampled only on the advance edge; a DIR change mid-slot never shortens or repeats the current slot.
REQ-019 SEL, IDX and SLOT_START SHALL be decoded from registers only, with no combinational path from EN, DIR or RST.
REQ-020 IDX SHALL equal idx at all times.
REQ-021 SLOT_START SHALL equal act AND (cnt==0).
REQ-022 SEL SHALL be onehot(idx) when act=1 and the blanking condition is false (see Configuration); otherwise all-zero.
REQ-023 At most one SEL bit SHALL be high in any cycle.
REQ-024 Steady-state scan period SHALL be exactly N*DIV cycles, with every channel active for the same number of cycles.
REQ-025 An illegal parameter combination SHALL abort elaboration via a generate-time error.

Reset
REQ-026 RST=1 SHALL force act=0, cnt=0 and idx=0 on the next edge, and SHALL dominate EN and DIR.
REQ-027 After reset, SEL=0, IDX=0 and SLOT_START=0 SHALL hold until act becomes 1.
REQ-028 Reset asserted mid-slot SHALL abandon the slot; scanning restarts at idx 0 with a full slot.

Configuration
REQ-029 The macro SCAN_DEADTIME_EN SHALL control dead-time blanking.
REQ-030 With SCAN_DEADTIME_EN defined, the blanking condition SHALL be cnt<DEAD, so each slot has DEAD all-zero cycles followed by DIV-DEAD active cycles.
REQ-031 With SCAN_DEADTIME_EN undefined, DEAD SHALL be ignored, the blanking condition SHALL be always false, and the dead-time comparator SHALL not be synthesised.

Verification
REQ-032 N=4, DIV=4, DEAD=1, macro on; RST then EN=1, DIR=0 -> per slot SEL=0000 for 1 cycle then 3 cycles of 0001, then 0010, 0100, 1000, repeating; IDX 0,1,2,3,0; SLOT_START every 4 cycles; period 16.
REQ-033 Same config; DIR set to 1 at cnt=1 while idx=1 -> slot 1 completes its full 4 cycles, then IDX goes to 0, then 3, then 2.
REQ-034 Same config; EN=0 at idx=2, cnt=2 -> next cycle SEL=0000, IDX holds 2, SLOT_START=0; EN=1 again -> SLOT_START pulses, then 1 blank cycle, then SEL=0100 for 3 cycles.
REQ-035 Same config; RST pulsed for 1 cycle at idx=3, cnt=2 with EN held 1 -> next cycle all outputs are 0; scanning resumes at IDX=0 with a full 4-cycle slot.
REQ-036 N=4, DIV=4, macro off -> SEL never 0000 while act=1; each one-hot value is held for 4 cycles.
REQ-037 N=2, DIV=2, DEAD=0, macro on -> SEL alternates 01, 01, 10, 10 with no blank cycle (complementary two-phase output).
